// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared types and helpers for the time-multiplexed FIR controller.
//   state_t   : controller FSM states (IDLE, MAC, OUT)
//   acc_width : accumulator width that cannot wrap over ORDER full-width products
//   saturate  : clamps a wide signed value to a w-bit signed range (only used
//               when the FIR_SAT_EN build option is defined)
// -----------------------------------------------------------------------------
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Each product needs data+coef bits; summing ORDER of them adds clog2(ORDER).
    function automatic int acc_width(input int data, input int coef, input int order);
        return data + coef + $clog2(order);
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int                  w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fir_mac_seq_if.sv
// -----------------------------------------------------------------------------
// fir_mac_seq_if
// Sample, coefficient-write and result bus of the FIR controller.
//   data_i/ch_i/vld_i/rdy_o      : input sample handshake
//   coef_we_i/coef_addr_i/coef_i : shadow coefficient bank write port
//   coef_swap_i                  : request to activate the shadow bank
//   data_o/ch_o/vld_o            : filtered sample with one-cycle strobe
// Modports: slave = the filter, master = the sample source / controller.
// -----------------------------------------------------------------------------
interface fir_mac_seq_if #(
    parameter int ORDER      = 16,
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int CHANNELS   = 2
);
    localparam int AW   = $clog2(ORDER);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic signed [DATA_WIDTH-1:0] data_i;
    logic        [CH_W-1:0]       ch_i;
    logic                         vld_i;
    logic                         rdy_o;
    logic                         coef_we_i;
    logic        [AW-1:0]         coef_addr_i;
    logic signed [COEF_WIDTH-1:0] coef_i;
    logic                         coef_swap_i;
    logic signed [DATA_WIDTH-1:0] data_o;
    logic        [CH_W-1:0]       ch_o;
    logic                         vld_o;

    modport slave (
        input  data_i, ch_i, vld_i, coef_we_i, coef_addr_i, coef_i, coef_swap_i,
        output rdy_o, data_o, ch_o, vld_o
    );

    modport master (
        output data_i, ch_i, vld_i, coef_we_i, coef_addr_i, coef_i, coef_swap_i,
        input  rdy_o, data_o, ch_o, vld_o
    );

endinterface

// File: rtl/fir_coef_bank.sv
// -----------------------------------------------------------------------------
// fir_coef_bank
// Double-buffered coefficient store. Writes always land in the shadow bank;
// a swap request is remembered and copied into the active bank on the first
// edge where the controller is idle, so a sample in flight never sees a mix.
//   clk, rst    : clock, asynchronous active-low reset (clears both banks)
//   we_i        : shadow write strobe, waddr_i / wdata_i : tap index / value
//   swap_i      : swap request, idle_i : controller is in IDLE this cycle
//   raddr_i     : tap index to read, coef_o : active coefficient (combinational)
// -----------------------------------------------------------------------------
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int ORDER      = 16,
    parameter int COEF_WIDTH = 16,
    localparam int AW        = $clog2(ORDER)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we_i,
    input  logic        [AW-1:0]         waddr_i,
    input  logic signed [COEF_WIDTH-1:0] wdata_i,
    input  logic                         swap_i,
    input  logic                         idle_i,
    input  logic        [AW-1:0]         raddr_i,
    output logic signed [COEF_WIDTH-1:0] coef_o
);

    logic signed [COEF_WIDTH-1:0] shd_q [ORDER];
    logic signed [COEF_WIDTH-1:0] act_q [ORDER];
    logic                         swap_pend_q;
    logic                         swap_pend_d;
    logic                         apply;

    assign apply = swap_pend_q && idle_i;

    // A request arriving on the same edge as an apply stays pending.
    always_comb begin
        swap_pend_d = swap_pend_q;
        if (apply)  swap_pend_d = 1'b0;
        if (swap_i) swap_pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ORDER; i++) begin
                shd_q[i] <= '0;
                act_q[i] <= '0;
            end
            swap_pend_q <= 1'b0;
        end else begin
            swap_pend_q <= swap_pend_d;
            if (we_i)  shd_q[waddr_i] <= wdata_i;
            if (apply) act_q <= shd_q;
        end
    end

    assign coef_o = act_q[raddr_i];

endmodule

// File: rtl/fir_mac_seq.sv
// -----------------------------------------------------------------------------
// fir_mac_seq
// Time-multiplexed FIR: one multiplier walks ORDER taps per sample across
// CHANNELS interleaved channels, each with its own circular sample buffer.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : fir_mac_seq_if.slave (sample handshake, coefficient port,
//              filtered output with one-cycle vld_o strobe)
// Build option FIR_SAT_EN: when defined, the scaled accumulator saturates to
// the DATA_WIDTH signed range; otherwise it wraps (low DATA_WIDTH bits).
// -----------------------------------------------------------------------------
module fir_mac_seq
    import fir_pkg::*;
#(
    parameter int ORDER      = 16,
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int CHANNELS   = 2
) (
    input  logic          clk,
    input  logic          rst,
    fir_mac_seq_if.slave  bus
);

    localparam int AW     = $clog2(ORDER);
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
    localparam int ACC_W  = acc_width(DATA_WIDTH, COEF_WIDTH, ORDER);

    state_t                       state_q;
    logic        [AW-1:0]         k_q;
    logic        [AW-1:0]         rd_q;
    logic        [CH_W-1:0]       ch_q;
    logic signed [ACC_W-1:0]      acc_q;
    logic signed [DATA_WIDTH-1:0] data_q;
    logic        [CH_W-1:0]       cho_q;
    logic                         vld_q;

    logic signed [DATA_WIDTH-1:0] smp_q  [CHANNELS][ORDER];
    logic        [AW-1:0]         wptr_q [CHANNELS];

    logic                         rdy;
    logic                         hs;
    logic        [AW-1:0]         wptr_cur;
    logic        [AW-1:0]         wptr_d;
    logic        [AW-1:0]         rd_d;
    logic signed [COEF_WIDTH-1:0] coef_act;
    logic signed [DATA_WIDTH-1:0] smp_rd;
    logic signed [PROD_W-1:0]     prod;
    logic signed [ACC_W-1:0]      prod_ext;
    logic signed [ACC_W-1:0]      shifted;
    logic signed [DATA_WIDTH-1:0] data_d;

    assign rdy = (state_q == IDLE) && rst;
    assign hs  = bus.vld_i && rdy;

    assign wptr_cur = wptr_q[bus.ch_i];
    assign wptr_d   = (wptr_cur == AW'(ORDER - 1)) ? '0 : wptr_cur + 1'b1;

    // The read pointer walks backwards from the newest sample, one tap per cycle.
    assign rd_d = (rd_q == '0) ? AW'(ORDER - 1) : rd_q - 1'b1;

    fir_coef_bank #(
        .ORDER      (ORDER),
        .COEF_WIDTH (COEF_WIDTH)
    ) u_coef (
        .clk     (clk),
        .rst     (rst),
        .we_i    (bus.coef_we_i),
        .waddr_i (bus.coef_addr_i),
        .wdata_i (bus.coef_i),
        .swap_i  (bus.coef_swap_i),
        .idle_i  (state_q == IDLE),
        .raddr_i (k_q),
        .coef_o  (coef_act)
    );

    assign smp_rd   = smp_q[ch_q][rd_q];
    assign prod     = smp_rd * coef_act;
    assign prod_ext = ACC_W'(prod);
    assign shifted  = acc_q >>> (COEF_WIDTH - 1);

`ifdef FIR_SAT_EN
    logic signed [63:0] sat_full;
    assign sat_full = saturate(64'(shifted), DATA_WIDTH);
    assign data_d   = sat_full[DATA_WIDTH-1:0];
`else
    assign data_d   = shifted[DATA_WIDTH-1:0];
`endif

    // Sample buffers and write pointers: one slot written per accepted sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wptr_q[c] <= '0;
                for (int t = 0; t < ORDER; t++) smp_q[c][t] <= '0;
            end
        end else if (hs) begin
            smp_q[bus.ch_i][wptr_cur] <= bus.data_i;
            wptr_q[bus.ch_i]          <= wptr_d;
        end
    end

    // Controller FSM with accumulator and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            rd_q    <= '0;
            ch_q    <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            cho_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        ch_q    <= bus.ch_i;
                        rd_q    <= wptr_cur;
                        k_q     <= '0;
                        acc_q   <= '0;
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_q + prod_ext;
                    rd_q  <= rd_d;
                    k_q   <= k_q + 1'b1;
                    if (k_q == AW'(ORDER - 1)) state_q <= OUT;
                end
                OUT: begin
                    data_q  <= data_d;
                    cho_q   <= ch_q;
                    vld_q   <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rdy_o  = rdy;
    assign bus.data_o = data_q;
    assign bus.ch_o   = cho_q;
    assign bus.vld_o  = vld_q;

endmodule

// File: tb/tb_fir_mac_seq.sv
// -----------------------------------------------------------------------------
// tb_fir_mac_seq
// Directed bench for fir_mac_seq with ORDER=4, 16-bit data/coefficients and
// two channels. Expected values are hand-computed from the filter equation.
// -----------------------------------------------------------------------------
module tb_fir_mac_seq;

    localparam int ORDER = 4;
    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int CH    = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    fir_mac_seq_if #(.ORDER(ORDER), .DATA_WIDTH(DW), .COEF_WIDTH(CW), .CHANNELS(CH)) bus ();

    fir_mac_seq #(
        .ORDER      (ORDER),
        .DATA_WIDTH (DW),
        .COEF_WIDTH (CW),
        .CHANNELS   (CH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // All tasks below start and end just after a falling edge.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        chk({tag, "_rdy"},  longint'(bus.rdy_o),  0);
        chk({tag, "_data"}, longint'(bus.data_o), 0);
        chk({tag, "_ch"},   longint'(bus.ch_o),   0);
        chk({tag, "_vld"},  longint'(bus.vld_o),  0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk({tag, "_rdy_rel"}, longint'(bus.rdy_o), 1);
    endtask

    task automatic load_coefs(input int c0, input int c1, input int c2, input int c3,
                              input bit do_swap);
        int c [4];
        c = '{c0, c1, c2, c3};
        for (int k = 0; k < 4; k++) begin
            bus.coef_we_i   = 1'b1;
            bus.coef_addr_i = 2'(k);
            bus.coef_i      = 16'(c[k]);
            @(negedge clk);
        end
        bus.coef_we_i = 1'b0;
        if (do_swap) begin
            bus.coef_swap_i = 1'b1;
            @(negedge clk);
            bus.coef_swap_i = 1'b0;
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    task automatic send(input int x, input int ch, input bit do_swap, input int exp_d,
                        input string tag);
        int n;
        int lat;
        bus.data_i = 16'(x);
        bus.ch_i   = 1'(ch);
        bus.vld_i  = 1'b1;
        n = 0;
        while (!bus.rdy_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 bus.vld_i = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            bus.coef_swap_i = do_swap && (lat == 1);
            if (lat == 1) chk({tag, "_rdy_mac"}, longint'(bus.rdy_o), 0);
        end while (!bus.vld_o && lat < 3 * ORDER);
        bus.coef_swap_i = 1'b0;
        chk({tag, "_lat"},  lat, ORDER + 2);
        chk({tag, "_data"}, longint'(bus.data_o), exp_d);
        chk({tag, "_ch"},   longint'(bus.ch_o), ch);
        @(negedge clk);
        chk({tag, "_vld_pulse"}, longint'(bus.vld_o), 0);
    endtask

    task automatic run_impulse(input string tag);
        load_coefs(16384, 8192, -8192, 0, 1'b1);
        send(32767, 0, 1'b0, 16383, {tag, "0"});
        send(0,     0, 1'b0, 8191,  {tag, "1"});
        send(0,     0, 1'b0, -8192, {tag, "2"});
        send(0,     0, 1'b0, 0,     {tag, "3"});
        send(0,     0, 1'b0, 0,     {tag, "4"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sat_exp [4];
        int seq  [5];
        int expv [5];
        int got  [$];
        int idx, t, last, nhs, extra;
        bit adv, seen;

        bus.data_i      = '0;
        bus.ch_i        = '0;
        bus.vld_i       = 1'b0;
        bus.coef_we_i   = 1'b0;
        bus.coef_addr_i = '0;
        bus.coef_i      = '0;
        bus.coef_swap_i = 1'b0;

        // Reset state and impulse response
        do_reset("rst0");
        run_impulse("imp");

        // Channel isolation: CH1 zeros interleaved with the CH0 impulse
        do_reset("rst1");
        load_coefs(16384, 8192, -8192, 0, 1'b1);
        send(32767, 0, 1'b0, 16383, "iso_a0");
        send(0,     1, 1'b0, 0,     "iso_b0");
        send(0,     0, 1'b0, 8191,  "iso_a1");
        send(0,     1, 1'b0, 0,     "iso_b1");
        send(0,     0, 1'b0, -8192, "iso_a2");
        send(0,     1, 1'b0, 0,     "iso_b2");
        send(0,     0, 1'b0, 0,     "iso_a3");
        send(0,     1, 1'b0, 0,     "iso_b3");
        send(0,     0, 1'b0, 0,     "iso_a4");

        // Bank swap requested mid-sample: old bank finishes, next uses new
        do_reset("rst2");
        load_coefs(16384, 8192, -8192, 0, 1'b1);
        load_coefs(32767, 0, 0, 0, 1'b0);
        send(1000, 0, 1'b1, 500,  "swp_old");
        send(2000, 0, 1'b0, 1999, "swp_new");

        // Saturation / wrap with full-scale coefficients and samples
`ifdef FIR_SAT_EN
        sat_exp = '{32766, 32767, 32767, 32767};
`else
        sat_exp = '{32766, -4, 32762, -8};
`endif
        do_reset("rst3");
        load_coefs(32767, 32767, 32767, 32767, 1'b1);
        send(32767, 0, 1'b0, sat_exp[0], "sat0");
        send(32767, 0, 1'b0, sat_exp[1], "sat1");
        send(32767, 0, 1'b0, sat_exp[2], "sat2");
        send(32767, 0, 1'b0, sat_exp[3], "sat3");

        // Reset two cycles into MAC abandons the sample
        bus.data_i = 16'sd32767;
        bus.ch_i   = 1'b0;
        bus.vld_i  = 1'b1;
        @(posedge clk);
        #1 bus.vld_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rmid_rdy",  longint'(bus.rdy_o),  0);
        chk("rmid_data", longint'(bus.data_o), 0);
        chk("rmid_vld",  longint'(bus.vld_o),  0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.vld_o) seen = 1'b1;
            chk("rmid_rdy_held", longint'(bus.rdy_o), 0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rmid_rdy_after", longint'(bus.rdy_o), 1);
        repeat (ORDER + 3) begin
            if (bus.vld_o) seen = 1'b1;
            @(negedge clk);
        end
        chk("rmid_no_vld",     longint'(seen), 0);
        chk("rmid_data_after", longint'(bus.data_o), 0);
        run_impulse("rimp");

        // Backpressure: vld_i held high, next sample offered right after accept
        seq  = '{100, 200, 300, 400, 500};
        expv = '{50, 125, 175, 225, 275};
        do_reset("rst4");
        load_coefs(16384, 8192, -8192, 0, 1'b1);
        idx = 0; t = 0; last = -1; nhs = 0; adv = 1'b0;
        bus.data_i = 16'(seq[0]);
        bus.ch_i   = 1'b0;
        bus.vld_i  = 1'b1;
        while (got.size() < 5 && t < 200) begin
            if (bus.vld_o) got.push_back(int'(bus.data_o));
            if (bus.vld_i && bus.rdy_o) begin
                nhs++;
                if (last >= 0) chk("bp_spacing", t - last, ORDER + 2);
                last = t;
                adv  = 1'b1;
            end
            @(negedge clk);
            t++;
            if (adv) begin
                adv = 1'b0;
                idx++;
                if (idx < 5) bus.data_i = 16'(seq[idx]);
                else         bus.vld_i  = 1'b0;
            end
        end
        extra = 0;
        repeat (ORDER + 3) begin
            @(negedge clk);
            if (bus.vld_o) extra++;
        end
        chk("bp_outputs",    got.size(), 5);
        chk("bp_handshakes", nhs, 5);
        chk("bp_extra",      extra, 0);
        for (int i = 0; i < 5; i++) begin
            if (i < got.size()) chk($sformatf("bp_data%0d", i), got[i], expv[i]);
            else                chk($sformatf("bp_data%0d", i), -1, expv[i]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
